// File: rtl/rv32_mem_responder.sv
// rv32_mem_responder
//   Single-outstanding RV32 data-memory responder with programmable wait
//   states. A request is accepted in IDLE, held for WAIT_CYCLES wait states,
//   then a response is presented in RESP until the core takes it.
//
//   Optional macro: PITO_MEM_ERR_EN
//     defined   -> misaligned (addr[1:0]!=0) or out-of-range
//                  (addr >= 4*DEPTH_WORDS) accesses return rsp_err=1,
//                  rsp_rdata=0 and never write storage.
//     undefined -> rsp_err is always 0, addr[1:0] ignored, high bits wrap.
//
//   Ports
//     clk, rst              clock, asynchronous active-high reset
//     req_valid/req_ready   request handshake
//     req_we, req_addr,
//     req_wdata, req_be     request payload (store/load, byte addr, data, byte enables)
//     rsp_valid/rsp_ready   response handshake
//     rsp_rdata, rsp_err    response payload (load data, 0 for stores; error flag)
//     dbg_state             current FSM state (IDLE=0, WAIT=1, RESP=2)
//
//   Handshake: a transfer happens on a rising edge where valid && ready are
//   both high. The payload is only looked at on that edge; the responder
//   keeps rsp_* stable for as long as rsp_valid is high and rsp_ready is low.

module rv32_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  // Access performed on the edge entering RESP. With zero wait states that
  // edge is the acceptance edge itself, so the live request fields are used.
  logic          cur_we;
  logic [31:0]   cur_addr;
  logic [31:0]   cur_wdata;
  logic [3:0]    cur_be;
  logic [AW-1:0] cur_idx;
  logic          addr_err;
  logic          enter_resp;
  logic          mem_wr;

  assign cur_we    = (state_q == IDLE) ? req_we    : we_q;
  assign cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign cur_be    = (state_q == IDLE) ? req_be    : be_q;
  assign cur_idx   = cur_addr[AW+1:2];

`ifdef PITO_MEM_ERR_EN
  assign addr_err = (cur_addr[1:0] != 2'b00) ||
                    (cur_addr >= 32'(4 * DEPTH_WORDS));
`else
  assign addr_err = 1'b0;
  // Bits outside the word index are intentionally ignored in this build.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cur_addr[31:AW+2], cur_addr[1:0]};
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (WAIT_CYCLES == 0) begin
            enter_resp = 1'b1;
            state_d    = RESP;
          end else begin
            cnt_d   = 4'(WAIT_CYCLES);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // One extra edge at cnt==0 gives WAIT_CYCLES+1 edges to rsp_valid.
        if (cnt_q == 4'd0) begin
          enter_resp = 1'b1;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (enter_resp) begin
      err_d   = addr_err;
      rdata_d = (cur_we || addr_err) ? 32'd0 : mem[cur_idx];
    end
  end

  assign mem_wr = enter_resp && cur_we && !addr_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately not reset; rst only blocks a pending write.
  always_ff @(posedge clk) begin
    if (mem_wr && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_be[b]) mem[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
`ifdef PITO_MEM_ERR_EN
  assign rsp_err   = err_q;
`else
  assign rsp_err   = 1'b0;
  logic unused_err;
  assign unused_err = err_q;
`endif
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rv32_mem_responder.sv
module tb_rv32_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // {err, rdata} expected per issued request
  logic [32:0] exp_q[$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  rv32_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  // ---------------- driver ----------------
  // Issues one request, checks latency, optionally holds rsp_ready low for
  // 'hold' cycles, compares against the scoreboard, then completes handshake.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] exp_rdata,
                       input logic exp_err, input int hold);
    int edges;
    logic [32:0] snap;
    logic [32:0] exp;
    @(negedge clk);
    check("req_ready_idle", 33'(req_ready), 33'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    exp_q.push_back({exp_err, exp_rdata});
    @(posedge clk); #1;
    // Garbage store request while busy must be ignored.
    req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF;
    req_addr  = 32'($urandom_range(0, 4095)); req_wdata = $urandom;
    edges = 0;
    while (!rsp_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    check("latency", 33'(edges), 33'd3);
    check("req_ready_busy", 33'(req_ready), 33'd0);
    snap = {rsp_err, rsp_rdata};
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 33'(rsp_valid), 33'd1);
      check("hold_data", {rsp_err, rsp_rdata}, snap);
      check("hold_req_ready", 33'(req_ready), 33'd0);
    end
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check("rsp_rdata", 33'(rsp_rdata), 33'(exp[31:0]));
      check("rsp_err", 33'(rsp_err), 33'(exp[32]));
    end else begin
      check("scoreboard_empty", 33'd0, 33'd1);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_valid_drop", 33'(rsp_valid), 33'd0);
    check("back_to_idle", 33'(dbg_state), 33'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] raddr;
    logic [31:0] rdat;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", 33'(req_ready), 33'd1);
    check("reset_rsp_valid", 33'(rsp_valid), 33'd0);
    check("reset_rsp_rdata", 33'(rsp_rdata), 33'd0);
    check("reset_rsp_err",   33'(rsp_err), 33'd0);
    @(negedge clk);
    rst = 1'b0;

    add(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    add(1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0);
    add(1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0);
    add(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 32'h0, 1'b0);
    add(1'b0, 32'h20, 32'h0,        4'hF, 32'h11BB33DD, 1'b0);
    add(1'b1, 32'h30, 32'h01020304, 4'hF, 32'h0, 1'b0);
    add(1'b1, 32'h30, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
    add(1'b0, 32'h30, 32'h0,        4'h0, 32'h01020304, 1'b0);
    add(1'b1, 32'h30, 32'hA0B0C0D0, 4'hA, 32'h0, 1'b0);
    add(1'b0, 32'h30, 32'h0,        4'h0, 32'hA002C004, 1'b0);
    add(1'b1, 32'h0,  32'h12345678, 4'hF, 32'h0, 1'b0);
`ifdef PITO_MEM_ERR_EN
    add(1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 32'h0, 1'b1);
    add(1'b0, 32'h0,    32'h0,        4'h0, 32'h12345678, 1'b0);
    add(1'b0, 32'h13,   32'h0,        4'h0, 32'h0, 1'b1);
`else
    add(1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
    add(1'b0, 32'h0,    32'h0,        4'h0, 32'hCAFEF00D, 1'b0);
    add(1'b0, 32'h13,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0);
`endif

    foreach (vecs[i])
      issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
            vecs[i].exp_rdata, vecs[i].exp_err, 0);

    // Response back-pressure: rsp_ready low for 5 cycles on a load.
    issue(1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 5);

    // Random store/load pairs in a region untouched by the table.
    for (int k = 0; k < 4; k++) begin
      raddr = 32'($urandom_range(64, 127)) << 2;
      rdat  = $urandom;
      issue(1'b1, raddr, rdat, 4'hF, 32'h0, 1'b0, 0);
      issue(1'b0, raddr, 32'h0, 4'h0, rdat, 1'b0, $urandom_range(0, 2));
    end

    // Reset while a store is waiting: abandon it, storage keeps old data.
    issue(1'b1, 32'h40, 32'h11111111, 4'hF, 32'h0, 1'b0, 0);
    issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40;
    req_wdata = 32'h5A5A5A5A; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("wait_before_rst", 33'(dbg_state), 33'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_req_ready", 33'(req_ready), 33'd1);
    check("rst_rsp_valid", 33'(rsp_valid), 33'd0);
    check("rst_rsp_rdata", 33'(rsp_rdata), 33'd0);
    check("rst_rsp_err",   33'(rsp_err), 33'd0);
    check("rst_state",     33'(dbg_state), 33'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(1'b0, 32'h40, 32'h0, 4'h0, 32'h11111111, 1'b0, 0);

    check("scoreboard_drained", 33'(exp_q.size()), 33'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
